// File: rtl/cmos_frame_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : cmos_frame_packer                                               |
// | Purpose  : packs an RGB565 pixel stream into address-tagged write words,   |
// |            buffered in a show-ahead FIFO toward the DDR write arbiter.     |
// |            Define DOUBLE_BUF_EN to ping-pong between two frame buffers.    |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module cmos_frame_packer #(
  parameter int                WORD_PIX    = 8,
  parameter int                FIFO_DEPTH  = 16,
  parameter int                ADDR_W      = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] LINE_STRIDE = ADDR_W'(2048),
  parameter logic [ADDR_W-1:0] BUF1_ADDR   = ADDR_W'(28'h100000)
) (
  input  logic                    pixel_clk,
  input  logic                    rst_n,
  input  logic [15:0]             pdata_i,
  input  logic                    de_i,
  input  logic                    vs_i,
  output logic [16*WORD_PIX-1:0]  wr_data_o,
  output logic [ADDR_W-1:0]       wr_addr_o,
  output logic                    wr_valid_o,
  input  logic                    wr_ready_i,
  output logic                    frame_done_o,
  output logic                    ovf_o,
  output logic                    buf_sel_o
);

  localparam int                C_DW         = 16 * WORD_PIX;
  localparam int                C_CW         = (WORD_PIX > 1) ? $clog2(WORD_PIX) : 1;
  localparam int                C_PW         = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] C_WORD_BYTES = ADDR_W'(2 * WORD_PIX);
  localparam logic [C_CW-1:0]   C_LAST_SLOT  = C_CW'(WORD_PIX - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_done;

  logic                r_vs_d;
  logic                r_de_d;
  logic [C_CW-1:0]     r_cnt;
  logic [C_DW-1:0]     r_pack;
  logic                r_push;
  logic [C_DW-1:0]     r_push_data;
  logic [ADDR_W-1:0]   r_push_addr;
  logic [ADDR_W-1:0]   r_line_addr;
  logic [ADDR_W-1:0]   r_word_addr;
  logic                r_ovf;
  logic                r_buf_sel;
  logic                r_frame_done;
  logic [C_PW:0]       r_wr_ptr;
  logic [C_PW:0]       r_rd_ptr;
  logic [C_DW+ADDR_W-1:0] r_mem [FIFO_DEPTH];

  logic                w_vs_rise;
  logic                w_vs_fall;
  logic                w_pix;
  logic                w_de_fall;
  logic                w_emit;
  logic [C_DW-1:0]     w_word;
  logic                w_sel_nxt;
  logic [ADDR_W-1:0]   w_base;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [C_DW+ADDR_W-1:0] w_head;

  assign w_vs_rise = vs_i & ~r_vs_d;
  assign w_vs_fall = ~vs_i & r_vs_d;
  assign w_pix     = (r_state == S_ACTIVE) & de_i;
  assign w_de_fall = (r_state == S_ACTIVE) & r_de_d & ~de_i;
  assign w_emit    = (w_pix & (r_cnt == C_LAST_SLOT)) | (w_de_fall & (r_cnt != '0));

  // Current pack register with the incoming pixel merged into its slot
  always_comb begin
    w_word = r_pack;
    if (w_pix) begin
      w_word[{r_cnt, 4'b0000} +: 16] = pdata_i;
    end
  end

`ifdef DOUBLE_BUF_EN
  logic r_started;
  assign w_sel_nxt = r_started ? ~r_buf_sel : r_buf_sel;
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_started <= 1'b0;
    end else if (w_vs_rise) begin
      r_started <= 1'b1;
    end
  end
`else
  assign w_sel_nxt = 1'b0;
`endif
  assign w_base = w_sel_nxt ? BUF1_ADDR : BASE_ADDR;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[C_PW] != r_rd_ptr[C_PW]) &&
                   (r_wr_ptr[C_PW-1:0] == r_rd_ptr[C_PW-1:0]);
  assign w_pop   = ~w_empty & wr_ready_i;
  // A pop in the same cycle frees the slot, so a push into a full FIFO survives
  assign w_push  = r_push & (~w_full | w_pop);
  assign w_drop  = r_push & w_full & ~w_pop;
  assign w_head  = r_mem[r_rd_ptr[C_PW-1:0]];

  assign wr_valid_o   = ~w_empty;
  assign wr_data_o    = w_empty ? '0 : w_head[C_DW-1:0];
  assign wr_addr_o    = w_empty ? '0 : w_head[C_DW+ADDR_W-1:C_DW];
  assign frame_done_o = r_frame_done;
  assign ovf_o        = r_ovf;
  assign buf_sel_o    = r_buf_sel;

  always_ff @(posedge pixel_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[C_PW-1:0]] <= {r_push_addr, r_push_data};
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:   if (w_vs_rise) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (w_vs_fall) w_state_nxt = S_FLUSH;
      S_FLUSH: begin
        if (w_vs_rise) begin
          w_state_nxt = S_ACTIVE;
          w_done      = 1'b1;
        end else if (w_empty & ~r_push) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d       <= 1'b0;
      r_de_d       <= 1'b0;
      r_cnt        <= '0;
      r_pack       <= '0;
      r_push       <= 1'b0;
      r_push_data  <= '0;
      r_push_addr  <= '0;
      r_line_addr  <= BASE_ADDR;
      r_word_addr  <= BASE_ADDR;
      r_ovf        <= 1'b0;
      r_buf_sel    <= 1'b0;
      r_frame_done <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_vs_d       <= vs_i;
      r_de_d       <= de_i;
      r_push       <= 1'b0;
      r_frame_done <= w_done;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_drop) r_ovf    <= 1'b1;

      if (w_emit) begin
        r_push      <= 1'b1;
        r_push_data <= w_word;
        r_push_addr <= r_word_addr;
        r_word_addr <= r_word_addr + C_WORD_BYTES;
        r_cnt       <= '0;
        r_pack      <= '0;
      end else if (w_pix) begin
        r_pack      <= w_word;
        r_cnt       <= r_cnt + 1'b1;
      end

      // Line end moves both pointers to the next line start
      if (w_de_fall) begin
        r_line_addr <= r_line_addr + LINE_STRIDE;
        r_word_addr <= r_line_addr + LINE_STRIDE;
      end

      if (w_vs_rise) begin
        r_line_addr <= w_base;
        r_word_addr <= w_base;
        r_cnt       <= '0;
        r_pack      <= '0;
        r_ovf       <= 1'b0;
        r_buf_sel   <= w_sel_nxt;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cmos_frame_packer.sv
`default_nettype none
// Testbench for cmos_frame_packer: random frames checked against a word-level
// model of the expected (address, data) stream, plus literal pins.
module tb_cmos_frame_packer;
  localparam int WP     = 8;
  localparam int DW     = 16 * WP;
  localparam int AW     = 28;
  localparam int STRIDE = 2048;
  localparam logic [AW-1:0] BUF1 = 28'h100000;

  logic          pixel_clk = 1'b0;
  logic          rst_n     = 1'b0;
  logic [15:0]   pdata_i   = '0;
  logic          de_i      = 1'b0;
  logic          vs_i      = 1'b0;
  logic          wr_ready_i = 1'b0;
  logic [DW-1:0] wr_data_o;
  logic [AW-1:0] wr_addr_o;
  logic          wr_valid_o;
  logic          frame_done_o;
  logic          ovf_o;
  logic          buf_sel_o;

  cmos_frame_packer dut (
    .pixel_clk   (pixel_clk),
    .rst_n       (rst_n),
    .pdata_i     (pdata_i),
    .de_i        (de_i),
    .vs_i        (vs_i),
    .wr_data_o   (wr_data_o),
    .wr_addr_o   (wr_addr_o),
    .wr_valid_o  (wr_valid_o),
    .wr_ready_i  (wr_ready_i),
    .frame_done_o(frame_done_o),
    .ovf_o       (ovf_o),
    .buf_sel_o   (buf_sel_o)
  );

  always #5 pixel_clk = ~pixel_clk;

  int            checks = 0;
  int            failures = 0;
  int            done_cnt = 0;
  int            ready_mode = 0;
  int            frame_no = 0;
  int            line_idx = 0;
  logic [AW-1:0] cur_base = '0;
  logic          exp_sel = 1'b0;
  logic [15:0]   line_px [0:255];
  logic [DW-1:0] exp_data [$];
  logic [AW-1:0] exp_addr [$];
  logic [DW-1:0] got_data [$];
  logic [AW-1:0] got_addr [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Compare process: every accepted word against the model, and hold stability
  logic          hold = 1'b0;
  logic [DW-1:0] hold_d;
  logic [AW-1:0] hold_a;
  always @(negedge pixel_clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_data", wr_data_o, hold_d);
        check("hold_addr", wr_addr_o, hold_a);
      end
      if (wr_valid_o && wr_ready_i) begin
        got_data.push_back(wr_data_o);
        got_addr.push_back(wr_addr_o);
        if (exp_data.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", wr_addr_o);
        end else begin
          check("word_addr", wr_addr_o, exp_addr.pop_front());
          check("word_data", wr_data_o, exp_data.pop_front());
        end
      end
      hold   = wr_valid_o && !wr_ready_i;
      hold_d = wr_data_o;
      hold_a = wr_addr_o;
      if (frame_done_o) done_cnt++;
    end
  end

  initial forever begin
    @(posedge pixel_clk);
    #1;
    case (ready_mode)
      0:       wr_ready_i = 1'b1;
      1:       wr_ready_i = 1'b0;
      2:       wr_ready_i = ~wr_ready_i;
      default: wr_ready_i = ($urandom % 4) != 0;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  // Expected words of one line: 8 pixels per word, zero-filled tail
  function automatic void model_line(input int n, input int limit);
    int nw;
    nw = (n + WP - 1) / WP;
    for (int k = 0; k < nw; k++) begin
      logic [DW-1:0] d;
      d = '0;
      for (int j = 0; j < WP; j++)
        if (k * WP + j < n) d[16*j +: 16] = line_px[k*WP + j];
      if (k < limit) begin
        exp_data.push_back(d);
        exp_addr.push_back(cur_base + AW'(line_idx * STRIDE) + AW'(16 * k));
      end
    end
    line_idx++;
  endfunction

  task automatic frame_start();
    vs_i = 1'b1;
    frame_no++;
    line_idx = 0;
`ifdef DOUBLE_BUF_EN
    exp_sel = (frame_no % 2) == 0;
`else
    exp_sel = 1'b0;
`endif
    cur_base = exp_sel ? BUF1 : '0;
    tick();
    tick();
    check("buf_sel", buf_sel_o, exp_sel);
    check("ovf_clear", ovf_o, 0);
  endtask

  task automatic send_line(input int n, input int limit);
    model_line(n, limit);
    for (int i = 0; i < n; i++) begin
      de_i = 1'b1;
      pdata_i = line_px[i];
      tick();
    end
    de_i = 1'b0;
    pdata_i = 16'($urandom);
    repeat (1 + $urandom % 4) tick();
  endtask

  task automatic frame_end(input logic exp_ovf);
    int start;
    int t;
    start = done_cnt;
    t = 0;
    vs_i = 1'b0;
    while (done_cnt == start && t < 4000) begin
      tick();
      t++;
    end
    checks++;
    if (done_cnt == start) begin
      failures++;
      $display("FAIL frame_done_timeout actual=none required=pulse");
    end
    repeat (3) tick();
    check("done_pulses", done_cnt - start, 1);
    check("exp_drained", exp_data.size(), 0);
    check("ovf_end", ovf_o, exp_ovf);
  endtask

  task automatic rand_frame();
    int nl;
    int n;
    frame_start();
    nl = 1 + $urandom % 4;
    for (int l = 0; l < nl; l++) begin
      n = 1 + $urandom % 40;
      for (int i = 0; i < n; i++) line_px[i] = 16'($urandom);
      send_line(n, 999);
    end
    frame_end(1'b0);
  endtask

  int g0;
  int d0;
  initial begin
    repeat (3) tick();
    check("rst_valid", wr_valid_o, 0);
    check("rst_data", wr_data_o, 0);
    check("rst_addr", wr_addr_o, 0);
    check("rst_done", frame_done_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_sel", buf_sel_o, 0);
    rst_n = 1'b1;
    ready_mode = 0;
    tick();
    tick();

    // One 16-pixel line, latency and literal word contents
    frame_start();
    for (int i = 0; i < 16; i++) line_px[i] = 16'(i + 1);
    model_line(16, 999);
    g0 = got_data.size();
    for (int i = 0; i < 16; i++) begin
      de_i = 1'b1;
      pdata_i = line_px[i];
      tick();
      if (i == 7) check("latency_lo", wr_valid_o, 0);
      if (i == 8) begin
        check("latency_hi", wr_valid_o, 1);
        check("t1_addr0", wr_addr_o, 28'h0);
        check("t1_data0", wr_data_o, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      end
    end
    de_i = 1'b0;
    tick();
    tick();
    frame_end(1'b0);
    check("t1_addr1", got_addr[g0+1], 28'h10);
    check("t1_data1", got_data[g0+1], 128'h0010_000f_000e_000d_000c_000b_000a_0009);

    // Short line with partial word, second line at stride
    frame_start();
    for (int i = 0; i < 10; i++) line_px[i] = 16'(i + 1);
    g0 = got_data.size();
    send_line(10, 999);
    for (int i = 0; i < 8; i++) line_px[i] = 16'($urandom);
    send_line(8, 999);
    frame_end(1'b0);
    check("t2_addr0", got_addr[g0], cur_base);
    check("t2_data1", got_data[g0+1], 128'h000a_0009);
    check("t2_line2", got_addr[g0+2], cur_base + 28'h800);

    // Overflow: ready held low across two 160-pixel lines
    frame_start();
    ready_mode = 1;
    g0 = got_data.size();
    for (int i = 0; i < 160; i++) line_px[i] = 16'($urandom);
    send_line(160, 16);
    for (int i = 0; i < 160; i++) line_px[i] = 16'($urandom);
    send_line(160, 0);
    check("t3_ovf_set", ovf_o, 1);
    check("t3_valid", wr_valid_o, 1);
    ready_mode = 0;
    frame_end(1'b1);
    check("t3_count", got_data.size() - g0, 16);
    check("t3_last", got_addr[got_addr.size()-1], cur_base + 28'hF0);

    // Toggling ready, then random ready; several frames exercise buffer select
    ready_mode = 2;
    repeat (2) rand_frame();
    ready_mode = 3;
    repeat (5) rand_frame();

    // Asynchronous reset mid-line with words queued
    ready_mode = 1;
    frame_start();
    for (int i = 0; i < 28; i++) begin
      de_i = 1'b1;
      pdata_i = 16'($urandom);
      tick();
    end
    check("t6_queued", wr_valid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_valid0", wr_valid_o, 0);
    check("t6_data0", wr_data_o, 0);
    check("t6_addr0", wr_addr_o, 0);
    check("t6_ovf0", ovf_o, 0);
    check("t6_sel0", buf_sel_o, 0);
    check("t6_done0", frame_done_o, 0);
    exp_data.delete();
    exp_addr.delete();
    de_i = 1'b0;
    vs_i = 1'b0;
    frame_no = 0;
    g0 = got_data.size();
    d0 = done_cnt;
    tick();
    rst_n = 1'b1;
    ready_mode = 0;
    repeat (40) tick();
    check("t6_no_words", got_data.size() - g0, 0);
    check("t6_no_done", done_cnt - d0, 0);

    ready_mode = 3;
    rand_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
